// File: rtl/axis_arb_mux_pkg.sv
// Shared constants and helpers for the AXI-Stream packet arbiter/mux.
package axis_arb_mux_pkg;

  localparam string ARB_ROUND_ROBIN = "ROUND_ROBIN";
  localparam string ARB_PRIORITY    = "PRIORITY";

  // Width of a binary input index; never narrower than one bit.
  function automatic int calc_gw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_arb_mux_rr_arbiter.sv
// Combinational round-robin / fixed-priority request arbiter.
module axis_arb_mux_rr_arbiter
  import axis_arb_mux_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = calc_gw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  input  logic          prio_mode,
  output logic [N-1:0]  gnt,
  output logic [GW-1:0] idx,
  output logic          valid
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [GW-1:0]  start;
  int             off;
  int             pos;

  // Rotating the doubled vector puts the pointer position at bit 0, so the
  // search is a plain lowest-set-bit scan.
  assign start   = prio_mode ? '0 : ptr;
  assign req_dbl = {req, req};
  assign req_rot = N'(req_dbl >> start);
  assign valid   = |req;

  always_comb begin
    off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) off = j;
    end
    pos = int'(start) + off;
    if (pos >= N) pos = pos - N;
    idx = GW'(pos);
    gnt = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/axis_arb_mux.sv
// N-to-1 AXI-Stream packet mux; the grant is held from first beat to tlast.
module axis_arb_mux
  import axis_arb_mux_pkg::*;
#(
  parameter int    N          = 2,
  parameter int    DATA_BYTES = 8,
  parameter int    USER_WIDTH = 1,
  parameter int    ID_WIDTH   = 1,
  parameter int    DEST_WIDTH = 1,
  parameter string ARB_TYPE   = "ROUND_ROBIN",
  localparam int   GW         = calc_gw(N),
  localparam int   DW         = DATA_BYTES * 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               s_tvalid,
  output logic [N-1:0]               s_tready,
  input  logic [N*DW-1:0]            s_tdata,
  input  logic [N*DATA_BYTES-1:0]    s_tstrb,
  input  logic [N*DATA_BYTES-1:0]    s_tkeep,
  input  logic [N-1:0]               s_tlast,
  input  logic [N*ID_WIDTH-1:0]      s_tid,
  input  logic [N*DEST_WIDTH-1:0]    s_tdest,
  input  logic [N*USER_WIDTH-1:0]    s_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DW-1:0]              m_tdata,
  output logic [DATA_BYTES-1:0]      m_tstrb,
  output logic [DATA_BYTES-1:0]      m_tkeep,
  output logic                       m_tlast,
  output logic [ID_WIDTH-1:0]        m_tid,
  output logic [DEST_WIDTH-1:0]      m_tdest,
  output logic [USER_WIDTH-1:0]      m_tuser,
  output logic [N-1:0]               grant,
  output logic                       grant_valid,
  output logic [GW-1:0]              grant_encoded
);

  localparam logic PRIO = (ARB_TYPE == ARB_PRIORITY);

  if (ARB_TYPE != ARB_ROUND_ROBIN && ARB_TYPE != ARB_PRIORITY) begin : g_bad_arb_type
    $error("axis_arb_mux: unsupported ARB_TYPE %s", ARB_TYPE);
  end
  if (N < 1) begin : g_bad_n
    $error("axis_arb_mux: N must be at least 1");
  end

  logic          locked;
  logic [GW-1:0] sel_reg;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] arb_sel;
  logic [GW-1:0] sel;
  logic [N-1:0]  arb_gnt;
  logic [N-1:0]  sel_onehot;
  logic          arb_valid;
  logic          active;
  logic          sel_valid;
  logic          accept;

  axis_arb_mux_rr_arbiter #(
    .N  (N),
    .GW (GW)
  ) u_arb (
    .req       (s_tvalid),
    .ptr       (rr_ptr),
    .prio_mode (PRIO),
    .gnt       (arb_gnt),
    .idx       (arb_sel),
    .valid     (arb_valid)
  );

  assign sel    = locked ? sel_reg : arb_sel;
  // Reset also gates the live arbiter so nothing is offered while held in reset.
  assign active = (locked | arb_valid) & ~reset;

  always_comb begin
    m_tdata    = '0;
    m_tstrb    = '0;
    m_tkeep    = '0;
    m_tlast    = 1'b0;
    m_tid      = '0;
    m_tdest    = '0;
    m_tuser    = '0;
    sel_valid  = 1'b0;
    sel_onehot = '0;
    s_tready   = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) begin
        m_tdata       = s_tdata[i*DW +: DW];
        m_tstrb       = s_tstrb[i*DATA_BYTES +: DATA_BYTES];
        m_tkeep       = s_tkeep[i*DATA_BYTES +: DATA_BYTES];
        m_tlast       = s_tlast[i];
        m_tid         = s_tid[i*ID_WIDTH +: ID_WIDTH];
        m_tdest       = s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        m_tuser       = s_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_valid     = s_tvalid[i];
        sel_onehot[i] = 1'b1;
        s_tready[i]   = active & m_tready;
      end
    end
  end

  assign m_tvalid      = active & sel_valid;
  assign accept        = m_tvalid & m_tready;
  assign grant         = active ? (locked ? sel_onehot : arb_gnt) : '0;
  assign grant_valid   = active;
  assign grant_encoded = reset ? '0 : sel;

  // A single-beat packet never locks but still moves the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked  <= 1'b0;
      sel_reg <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      if (!m_tlast) begin
        locked  <= 1'b1;
        sel_reg <= sel;
      end else begin
        locked <= 1'b0;
        if (!PRIO) rr_ptr <= (int'(sel) == N - 1) ? '0 : sel + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_arb_mux.sv
// Scoreboard bench for axis_arb_mux: four instances (RR N=4, PRIO N=4, RR N=3, N=1).
module tb_axis_arb_mux;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic [1:0]  strb;
    logic        last;
    logic [1:0]  user;
    logic        id;
    logic        dest;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  sv  [4];
  logic [63:0] sd  [4];
  logic [7:0]  ss  [4];
  logic [7:0]  sk  [4];
  logic [3:0]  sl  [4];
  logic [3:0]  si  [4];
  logic [3:0]  sde [4];
  logic [7:0]  su  [4];
  logic        mr  [4];
  logic [3:0]  sr  [4];
  logic [3:0]  gnt [4];
  logic [1:0]  ge  [4];
  logic        gv  [4];
  logic        mv  [4];
  logic [15:0] md  [4];
  logic [1:0]  ms  [4];
  logic [1:0]  mk  [4];
  logic        ml  [4];
  logic        mi  [4];
  logic        mde [4];
  logic [1:0]  mu  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int    NN  = (g == 2) ? 3 : ((g == 3) ? 1 : 4);
    localparam int    GWL = (NN > 1) ? $clog2(NN) : 1;
    localparam string AT  = (g == 1) ? "PRIORITY" : "ROUND_ROBIN";
    logic [NN-1:0]  tr;
    logic [NN-1:0]  gn;
    logic [GWL-1:0] gel;

    axis_arb_mux #(
      .N          (NN),
      .DATA_BYTES (2),
      .USER_WIDTH (2),
      .ID_WIDTH   (1),
      .DEST_WIDTH (1),
      .ARB_TYPE   (AT)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .s_tvalid      (sv[g][NN-1:0]),
      .s_tready      (tr),
      .s_tdata       (sd[g][NN*16-1:0]),
      .s_tstrb       (ss[g][NN*2-1:0]),
      .s_tkeep       (sk[g][NN*2-1:0]),
      .s_tlast       (sl[g][NN-1:0]),
      .s_tid         (si[g][NN-1:0]),
      .s_tdest       (sde[g][NN-1:0]),
      .s_tuser       (su[g][NN*2-1:0]),
      .m_tvalid      (mv[g]),
      .m_tready      (mr[g]),
      .m_tdata       (md[g]),
      .m_tstrb       (ms[g]),
      .m_tkeep       (mk[g]),
      .m_tlast       (ml[g]),
      .m_tid         (mi[g]),
      .m_tdest       (mde[g]),
      .m_tuser       (mu[g]),
      .grant         (gn),
      .grant_valid   (gv[g]),
      .grant_encoded (gel)
    );

    assign sr[g]  = 4'(tr);
    assign gnt[g] = 4'(gn);
    assign ge[g]  = 2'(gel);
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         seq  [4][4];
  bit         en   [4][4];
  int         len  [4];
  logic       mrdy [4];
  logic [3:0] acc  [4];
  beat_t      exp_q[4][$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source i of an instance emits a running sequence; payload is a pure function of it.
  function automatic beat_t mk_beat(input int src, input int sq, input int ln);
    beat_t b;
    b.data = {4'(src), 12'(sq)};
    b.keep = {sq[0], 1'b1};
    b.strb = {1'b1, sq[1]};
    b.last = ((sq % ln) == ln - 1);
    b.user = 2'(src);
    b.id   = sq[0];
    b.dest = src[0];
    return b;
  endfunction

  task automatic push(input int k, input int src, input int sq);
    exp_q[k].push_back(mk_beat(src, sq, len[k]));
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        b = mk_beat(i, seq[k][i], len[k]);
        sv[k][i]           = en[k][i];
        sd[k][i*16 +: 16]  = b.data;
        sk[k][i*2 +: 2]    = b.keep;
        ss[k][i*2 +: 2]    = b.strb;
        sl[k][i]           = b.last;
        su[k][i*2 +: 2]    = b.user;
        si[k][i]           = b.id;
        sde[k][i]          = b.dest;
      end
      mr[k] = mrdy[k];
    end
  endtask

  task automatic monitor();
    beat_t e;
    for (int k = 0; k < 4; k++) begin
      acc[k] = sv[k] & sr[k];
      if (mv[k] && mr[k]) begin
        if (exp_q[k].size() == 0) begin
          check_val($sformatf("sb%0d_extra_beat", k), 64'(exp_q[k].size()), 64'd1);
        end else begin
          e = exp_q[k].pop_front();
          check_val($sformatf("sb%0d_beat", k),
                    64'({md[k], mk[k], ms[k], ml[k], mu[k], mi[k], mde[k]}), 64'(e));
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        if (acc[k][i]) seq[k][i]++;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      acc[k] = '0;
      exp_q[k].delete();
      for (int i = 0; i < 4; i++) begin
        en[k][i]  = 1'b0;
        seq[k][i] = 0;
      end
    end
    drive();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      len[k]  = 1;
      mrdy[k] = 1'b0;
      acc[k]  = '0;
      for (int i = 0; i < 4; i++) begin
        en[k][i]  = 1'b0;
        seq[k][i] = 0;
      end
    end
    drive();
    #1;
    // Reset state with every input already requesting.
    for (int i = 0; i < 4; i++) en[0][i] = 1'b1;
    mrdy[0] = 1'b1;
    drive();
    #1;
    check_val("rst_grant", gnt[0], 0);
    check_val("rst_grant_valid", gv[0], 0);
    check_val("rst_grant_enc", ge[0], 0);
    check_val("rst_s_tready", sr[0], 0);
    check_val("rst_m_tvalid", mv[0], 0);
    reset_pulse();

    // Round robin, 3-beat packets, all inputs busy: 0,1,2,3,0 with no bubbles.
    len[0] = 3;
    mrdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) en[0][i] = 1'b1;
    for (int p = 0; p < 5; p++)
      for (int b = 0; b < 3; b++) push(0, p % 4, (p / 4) * 3 + b);
    for (int c = 0; c < 15; c++) begin
      cycle();
      check_val("rr4_m_tvalid", mv[0], 1);
      check_val("rr4_grant_enc", ge[0], 64'((c / 3) % 4));
    end
    for (int i = 0; i < 4; i++) en[0][i] = 1'b0;
    check_val("rr4_drain", 64'(exp_q[0].size()), 0);

    // Locked grant survives a source stall; input 0 waits for tlast.
    reset_pulse();
    len[0] = 4;
    mrdy[0] = 1'b1;
    for (int s = 0; s < 4; s++) push(0, 2, s);
    push(0, 0, 0);
    en[0][2] = 1'b1;
    cycle();
    check_val("stall_sel_b0", ge[0], 2);
    en[0][0] = 1'b1;
    cycle();
    check_val("stall_sel_b1", ge[0], 2);
    en[0][2] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cycle();
      check_val("stall_hold_sel", ge[0], 2);
      check_val("stall_m_tvalid", mv[0], 0);
      check_val("stall_s_tready0", sr[0][0], 0);
      check_val("stall_grant", gnt[0], 4'b0100);
    end
    en[0][2] = 1'b1;
    cycle();
    check_val("stall_sel_b2", ge[0], 2);
    cycle();
    check_val("stall_sel_b3", ge[0], 2);
    en[0][2] = 1'b0;
    cycle();
    check_val("stall_next_sel", ge[0], 0);
    check_val("stall_next_valid", mv[0], 1);
    en[0][0] = 1'b0;
    check_val("stall_drain", 64'(exp_q[0].size()), 0);

    // Fixed priority: input 1 always beats input 3.
    reset_pulse();
    len[1] = 2;
    mrdy[1] = 1'b1;
    en[1][1] = 1'b1;
    en[1][3] = 1'b1;
    for (int s = 0; s < 12; s++) push(1, 1, s);
    for (int c = 0; c < 12; c++) begin
      cycle();
      check_val("prio_grant_enc", ge[1], 1);
      check_val("prio_s_tready3", sr[1][3], 0);
    end
    en[1][1] = 1'b0;
    en[1][3] = 1'b0;
    check_val("prio_drain", 64'(exp_q[1].size()), 0);

    // N=3 single-beat packets under random backpressure rotate 0,1,2,...
    reset_pulse();
    len[2] = 1;
    for (int i = 0; i < 3; i++) en[2][i] = 1'b1;
    for (int s = 0; s < 12; s++) push(2, s % 3, s / 3);
    for (int c = 0; c < 200 && exp_q[2].size() > 0; c++) begin
      mrdy[2] = 1'($urandom_range(0, 1));
      cycle();
    end
    for (int i = 0; i < 3; i++) en[2][i] = 1'b0;
    mrdy[2] = 1'b0;
    check_val("rr3_drain", 64'(exp_q[2].size()), 0);

    // Reset mid-packet on input 1 after rr_ptr has moved past input 2.
    reset_pulse();
    len[0] = 2;
    mrdy[0] = 1'b1;
    push(0, 2, 0);
    push(0, 2, 1);
    push(0, 1, 0);
    push(0, 2, 2);
    push(0, 2, 3);
    en[0][2] = 1'b1;
    cycle();
    cycle();
    en[0][2] = 1'b0;
    en[0][1] = 1'b1;
    cycle();
    check_val("mid_sel", ge[0], 1);
    reset = 1'b1;
    acc[0] = '0;
    en[0][2] = 1'b1;
    en[0][3] = 1'b1;
    drive();
    #1;
    check_val("mid_rst_grant", gnt[0], 0);
    check_val("mid_rst_grant_valid", gv[0], 0);
    check_val("mid_rst_s_tready", sr[0], 0);
    for (int c = 0; c < 2; c++) begin
      cycle();
      check_val("mid_rst_hold_grant", gnt[0], 0);
      check_val("mid_rst_hold_valid", gv[0], 0);
      check_val("mid_rst_hold_enc", ge[0], 0);
      check_val("mid_rst_hold_m_tvalid", mv[0], 0);
    end
    reset = 1'b0;
    en[0][1] = 1'b0;
    drive();
    #1;
    check_val("post_rst_sel", ge[0], 2);
    check_val("post_rst_grant_valid", gv[0], 1);
    monitor();
    cycle();
    check_val("post_rst_hold", ge[0], 2);
    for (int i = 0; i < 4; i++) en[0][i] = 1'b0;
    check_val("post_rst_drain", 64'(exp_q[0].size()), 0);

    // N=1 pass-through with m_tready toggling every cycle.
    reset_pulse();
    len[3] = 3;
    en[3][0] = 1'b1;
    for (int s = 0; s < 5; s++) push(3, 0, s);
    for (int c = 0; c < 10; c++) begin
      mrdy[3] = ((c % 2) == 0);
      cycle();
      check_val("n1_s_tready", sr[3][0], mrdy[3]);
      check_val("n1_grant_enc", ge[3], 0);
      check_val("n1_m_tvalid", mv[3], 1);
    end
    en[3][0] = 1'b0;
    check_val("n1_drain", 64'(exp_q[3].size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_arb_mux.md
Name: axis_arb_mux

Overview:
- N-input to 1-output AXI-Stream packet multiplexer with a round-robin or fixed-priority arbiter.
- Selects one input per packet and holds that grant until the packet's tlast beat is accepted.
- Used by the MPLS ingress subsystem to merge per-physical-port streams onto the converged ingress bus.
- Port index travels in tuser, set upstream; the mux passes all sideband fields through unchanged.

Parameters:
- N, 2: number of input streams; must be ≥1.
- DATA_BYTES, 8: tdata width in bytes; tkeep and tstrb are DATA_BYTES bits.
- USER_WIDTH, 1: tuser width.
- ID_WIDTH, 1: tid width.
- DEST_WIDTH, 1: tdest width.
- ARB_TYPE, "ROUND_ROBIN": "ROUND_ROBIN" or "PRIORITY" (lowest index wins); any other value is an elaboration error.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s_tvalid  in  N  per-input valid.
- s_tready  out  N  per-input ready.
- s_tdata  in  N*DATA_BYTES*8  input i occupies slice [i*DATA_BYTES*8 +: DATA_BYTES*8].
- s_tstrb  in  N*DATA_BYTES  packed per input, same slicing rule.
- s_tkeep  in  N*DATA_BYTES  packed per input.
- s_tlast  in  N  per-input last.
- s_tid  in  N*ID_WIDTH  packed per input.
- s_tdest  in  N*DEST_WIDTH  packed per input.
- s_tuser  in  N*USER_WIDTH  packed per input.
- m_tvalid, m_tready, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out/in/out...  single-stream widths  output stream; m_tready is the only input.
- grant  out  N  one-hot index of the selected input.
- grant_valid  out  1  a selection is active.
- grant_encoded  out  GW=max(1,$clog2(N))  binary index of the selected input.

Behaviour:
- State: locked (1 bit), sel_reg (GW bits), rr_ptr (GW bits). Reset values: locked=0, sel_reg=0, rr_ptr=0.
- Arbiter, combinational, evaluated when locked=0:
  - ROUND_ROBIN picks the first asserted s_tvalid searching rr_ptr, rr_ptr+1, … with wrap mod N.
  - PRIORITY picks the lowest asserted index.
  - arb_valid = |s_tvalid.
- sel = locked ? sel_reg : arb_sel. active = locked | arb_valid.
- Datapath is zero-latency and combinational:
  - m_tvalid = active & s_tvalid[sel].
  - All m_ payload fields come from input sel.
  - s_tready[sel] = active & m_tready. All other s_tready are 0.
- Beat accepted when m_tvalid & m_tready.
  - Accepted with tlast=0: locked←1, sel_reg←sel.
  - Accepted with tlast=1: locked←0, and rr_ptr←(sel+1) mod N in ROUND_ROBIN mode. rr_ptr is unchanged in PRIORITY mode.
- A single-beat packet never sets locked but still advances rr_ptr. Consecutive single-beat packets therefore rotate with no bubble.
- While locked, a deasserted s_tvalid[sel] gives m_tvalid=0. Grant is held and other inputs stay stalled.
- Payload is undefined-but-stable when m_tvalid=0; it is driven from input sel.
- grant = active ? onehot(sel) : 0. grant_encoded = sel. grant_valid = active. During reset all three are 0.
- Reset asserted mid-packet: locked clears immediately. The partial packet is truncated downstream; no recovery is required.
- N=1: arbiter degenerates to a pass-through. GW=1 and rr_ptr stays 0.
- No data is modified or dropped. Throughput is one beat per cycle including at packet boundaries.

Decomposition:
- Shared package holds:
  - the ARB_TYPE string constants;
  - a function computing GW = max(1,$clog2(N)).
- One sub-module is natural: rr_arbiter.
  - Inputs: request vector, pointer, mode.
  - Outputs: one-hot grant, encoded index, valid.
  - Purely combinational, with a doubled-vector priority search.
- The top level holds the lock/pointer registers and the mux.

Test Plan:
- N=4, ROUND_ROBIN, all inputs valid with 3-beat packets, m_tready=1 -> packet order 0,1,2,3,0. No idle cycles. Each packet's beats contiguous with m_tuser equal to its source tuser.
- N=4, input 2 sends 4 beats with s_tvalid dropped on beat 3 for 2 cycles while input 0 is valid -> grant_encoded stays 2. m_tvalid=0 for those 2 cycles. Input 0 is granted only after input 2's tlast.
- N=4, PRIORITY, inputs 1 and 3 continuously sending 2-beat packets -> only input 1 is ever granted. s_tready[3]=0 throughout.
- N=3, single-beat packets on all inputs, random m_tready -> order 0,1,2,0…. tdata/tkeep/tlast match the source on every accepted beat. No duplicates.
- Reset asserted mid-packet on input 1 -> grant=0, grant_valid=0 and s_tready=0 within the reset. After release with input 2 valid, input 0 is checked first and input 2 is granted.
- N=1 pass-through with m_tready toggling every cycle -> output equals input. s_tready[0] equals m_tready. grant_encoded=0.
